// File: rtl/hough_pkg.sv
// Shared constants and types for the Hough processing stages.
package hough_pkg;

  localparam int DEF_PIX_W   = 8;
  localparam int DEF_COORD_W = 8;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_THRESH  = 128;

  typedef logic [DEF_PIX_W-1:0]   pixel_t;
  typedef logic [DEF_COORD_W-1:0] coord_t;

endpackage

// File: rtl/hough_sync_edges.sv
// Registers the frame/line framing signals and reports their edges.
// The edge outputs combine the live input with last cycle's sample, so an
// edge is reported in the same cycle the new level is first seen.
module hough_sync_edges (
  input  logic clk_i,
  input  logic reset_i,
  input  logic frame_i,
  input  logic line_i,
  output logic frame_rise_o,
  output logic frame_fall_o,
  output logic line_fall_o
);

  logic frame_q;
  logic line_q;

  // Previous-cycle samples. Reset loads 1 so that a frame already running
  // when reset is released is never mistaken for a new frame start.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      frame_q <= 1'b1;
      line_q  <= 1'b1;
    end else begin
      frame_q <= frame_i;
      line_q  <= line_i;
    end
  end

  assign frame_rise_o = frame_i & ~frame_q;
  assign frame_fall_o = ~frame_i & frame_q;
  assign line_fall_o  = ~line_i & line_q;

endmodule

// File: rtl/hough_peak.sv
// Finds the strongest accumulator cell of each frame and reports its
// position, value, threshold decision and the number of cells at or above
// threshold, all updated together with a one-cycle PeakValid pulse.
module hough_peak
  import hough_pkg::*;
#(
  parameter int PIX_W   = DEF_PIX_W,
  parameter int COORD_W = DEF_COORD_W,
  parameter int THRESH  = DEF_THRESH,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [PIX_W-1:0]   PixelIn,
  input  logic               FrameIn,
  input  logic               LineIn,
  output logic [COORD_W-1:0] PeakX,
  output logic [COORD_W-1:0] PeakY,
  output logic [PIX_W-1:0]   PeakVal,
  output logic               PeakFound,
  output logic [CNT_W-1:0]   HitCount,
  output logic               PeakValid
);

  localparam logic [PIX_W-1:0] THR = PIX_W'(THRESH);

  logic frame_rise, frame_fall, line_fall;
  logic pix_valid;

  logic               armed_q, armed_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [PIX_W-1:0]   cur_val_q, cur_val_d;
  logic [COORD_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [CNT_W-1:0]   hits_q, hits_d;

  logic [COORD_W-1:0] peak_x_q, peak_x_d, peak_y_q, peak_y_d;
  logic [PIX_W-1:0]   peak_val_q, peak_val_d;
  logic               peak_found_q, peak_found_d;
  logic [CNT_W-1:0]   peak_hits_q, peak_hits_d;
  logic               peak_valid_q, peak_valid_d;

  hough_sync_edges u_edges (
    .clk_i        (Clk),
    .reset_i      (Reset),
    .frame_i      (FrameIn),
    .line_i       (LineIn),
    .frame_rise_o (frame_rise),
    .frame_fall_o (frame_fall),
    .line_fall_o  (line_fall)
  );

  // Next-state for position counters, running max, hit count and results.
  // The frame-rise cycle is itself a pixel cycle, so the cleared values are
  // applied first and that pixel is then evaluated against them.
  always_comb begin
    armed_d      = armed_q;
    x_d          = x_q;
    y_d          = y_q;
    cur_val_d    = cur_val_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    hits_d       = hits_q;
    peak_x_d     = peak_x_q;
    peak_y_d     = peak_y_q;
    peak_val_d   = peak_val_q;
    peak_found_d = peak_found_q;
    peak_hits_d  = peak_hits_q;
    peak_valid_d = 1'b0;
    pix_valid    = 1'b0;

    if (frame_rise) begin
      armed_d   = 1'b1;
      x_d       = '0;
      y_d       = '0;
      cur_val_d = '0;
      cur_x_d   = '0;
      cur_y_d   = '0;
      hits_d    = '0;
    end else begin
      armed_d = armed_q;
    end

    pix_valid = armed_d & FrameIn & LineIn;

    if (pix_valid) begin
      // Strict compare: ties keep the earlier pixel in raster order.
      if (PixelIn > cur_val_d) begin
        cur_val_d = PixelIn;
        cur_x_d   = x_d;
        cur_y_d   = y_d;
      end else begin
        cur_val_d = cur_val_d;
      end
      if ((PixelIn >= THR) && (hits_d != '1)) begin
        hits_d = hits_d + CNT_W'(1);
      end else begin
        hits_d = hits_d;
      end
      x_d = (x_d == '1) ? x_d : x_d + COORD_W'(1);
    end else if (armed_d && FrameIn && line_fall) begin
      x_d = '0;
      y_d = (y_d == '1) ? y_d : y_d + COORD_W'(1);
    end else begin
      x_d = x_d;
    end

    // Frame end: publish the running values, which already include the
    // pixel sampled in the last FrameIn=1 cycle.
    if (frame_fall && armed_q) begin
      peak_x_d     = cur_x_q;
      peak_y_d     = cur_y_q;
      peak_val_d   = cur_val_q;
      peak_found_d = (cur_val_q >= THR);
      peak_hits_d  = hits_q;
      peak_valid_d = 1'b1;
      armed_d      = 1'b0;
    end else begin
      peak_valid_d = 1'b0;
    end
  end

  // State and result registers; reset wins over every other event.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      armed_q      <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      cur_val_q    <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      hits_q       <= '0;
      peak_x_q     <= '0;
      peak_y_q     <= '0;
      peak_val_q   <= '0;
      peak_found_q <= 1'b0;
      peak_hits_q  <= '0;
      peak_valid_q <= 1'b0;
    end else begin
      armed_q      <= armed_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cur_val_q    <= cur_val_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      hits_q       <= hits_d;
      peak_x_q     <= peak_x_d;
      peak_y_q     <= peak_y_d;
      peak_val_q   <= peak_val_d;
      peak_found_q <= peak_found_d;
      peak_hits_q  <= peak_hits_d;
      peak_valid_q <= peak_valid_d;
    end
  end

  assign PeakX     = peak_x_q;
  assign PeakY     = peak_y_q;
  assign PeakVal   = peak_val_q;
  assign PeakFound = peak_found_q;
  assign HitCount  = peak_hits_q;
  assign PeakValid = peak_valid_q;

endmodule

// File: tb/tb_hough_peak.sv
// Bench for hough_peak: table of frames with expected peak reports, plus a
// hand-written reset-mid-frame sequence. Expected reports are queued when a
// frame ends and compared when PeakValid pulses.
module tb_hough_peak;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [7:0]  PixelIn;
  logic        FrameIn;
  logic        LineIn;
  logic [7:0]  PeakX;
  logic [7:0]  PeakY;
  logic [7:0]  PeakVal;
  logic        PeakFound;
  logic [15:0] HitCount;
  logic        PeakValid;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  typedef struct {
    int w; int h; int bg;
    int p1x; int p1y; int p1v;
    int p2x; int p2y; int p2v;
    int together; int idle_after;
    int ex; int ey; int ev; int ef; int eh;
  } vec_t;

  typedef struct {
    int due; int x; int y; int val; int found; int hits;
  } exp_t;

  vec_t tbl[8];
  exp_t sb[$];

  hough_peak dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .PixelIn   (PixelIn),
    .FrameIn   (FrameIn),
    .LineIn    (LineIn),
    .PeakX     (PeakX),
    .PeakY     (PeakY),
    .PeakVal   (PeakVal),
    .PeakFound (PeakFound),
    .HitCount  (HitCount),
    .PeakValid (PeakValid)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic int pix_val(input vec_t v, input int c, input int r);
    if (c == v.p1x && r == v.p1y) return v.p1v;
    if (c == v.p2x && r == v.p2y) return v.p2v;
    return v.bg;
  endfunction

  // Drive one frame in raster order; FrameIn rises with the first pixel.
  task automatic drive_frame(input vec_t v);
    exp_t e;
    for (int r = 0; r < v.h; r++) begin
      for (int c = 0; c < v.w; c++) begin
        @(negedge Clk);
        FrameIn = 1'b1;
        LineIn  = 1'b1;
        PixelIn = 8'(pix_val(v, c, r));
      end
      if (!(v.together != 0 && r == v.h - 1)) begin
        @(negedge Clk);
        FrameIn = 1'b1;
        LineIn  = 1'b0;
        PixelIn = 8'd0;
      end
    end
    @(negedge Clk);
    FrameIn = 1'b0;
    LineIn  = 1'b0;
    PixelIn = 8'd0;
    e.due = cycle + 1;
    e.x = v.ex; e.y = v.ey; e.val = v.ev; e.found = v.ef; e.hits = v.eh;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      FrameIn = 1'b0;
      LineIn  = 1'b0;
      PixelIn = 8'd0;
    end
  endtask

  // Output monitor: compare each PeakValid pulse with the queued expectation.
  always @(posedge Clk) begin
    exp_t e;
    cycle++;
    #1;
    if (sb.size() > 0 && sb[0].due < cycle) begin
      e = sb.pop_front();
      chk("missing_peakvalid", 0, 1);
    end
    if (PeakValid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_peakvalid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("latency", cycle, e.due);
        chk("PeakX", int'(PeakX), e.x);
        chk("PeakY", int'(PeakY), e.y);
        chk("PeakVal", int'(PeakVal), e.val);
        chk("PeakFound", int'(PeakFound), e.found);
        chk("HitCount", int'(HitCount), e.hits);
      end
    end
  end

  initial begin
    //          w   h  bg  p1x p1y p1v  p2x p2y p2v tog idle  ex ey  ev ef eh
    tbl[0] = '{  4, 4, 10,   2,  1, 200,   2,  1, 200, 0, 3,   2, 1, 200, 1, 1};
    tbl[1] = '{  4, 3,  0,   1,  0, 150,   3,  2, 150, 0, 3,   1, 0, 150, 1, 2};
    tbl[2] = '{  8, 2, 127,  0,  0, 127,   0,  0, 127, 0, 3,   0, 0, 127, 0, 0};
    tbl[3] = '{  3, 3,  0,   2,  2, 255,   2,  2, 255, 1, 3,   2, 2, 255, 1, 1};
    tbl[4] = '{  2, 1, 128,  0,  0, 128,   0,  0, 128, 0, 3,   0, 0, 128, 1, 2};
    tbl[5] = '{  0, 3,  0,   0,  0,   0,   0,  0,   0, 0, 3,   0, 0,   0, 0, 0};
    tbl[6] = '{300, 1,  5, 280,  0, 200, 280,  0, 200, 0, 0, 255, 0, 200, 1, 1};
    tbl[7] = '{  2, 2, 130,  1,  1, 131,   1,  1, 131, 0, 3,   1, 1, 131, 1, 4};

    Reset   = 1'b1;
    FrameIn = 1'b0;
    LineIn  = 1'b0;
    PixelIn = 8'd0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    idle(2);
    chk("rst_PeakX", int'(PeakX), 0);
    chk("rst_PeakY", int'(PeakY), 0);
    chk("rst_PeakVal", int'(PeakVal), 0);
    chk("rst_PeakFound", int'(PeakFound), 0);
    chk("rst_HitCount", int'(HitCount), 0);
    chk("rst_PeakValid", int'(PeakValid), 0);

    foreach (tbl[i]) begin
      drive_frame(tbl[i]);
      idle(tbl[i].idle_after);
    end
    idle(4);

    // Frame A is cut by reset during row 1 and must produce no report.
    for (int c = 0; c < 4; c++) begin
      @(negedge Clk);
      FrameIn = 1'b1; LineIn = 1'b1; PixelIn = 8'd250;
    end
    @(negedge Clk);
    LineIn = 1'b0; PixelIn = 8'd0;
    for (int c = 0; c < 2; c++) begin
      @(negedge Clk);
      LineIn = 1'b1; PixelIn = 8'd240;
    end
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    #2;
    chk("midrst_PeakVal", int'(PeakVal), 0);
    chk("midrst_HitCount", int'(HitCount), 0);
    chk("midrst_PeakValid", int'(PeakValid), 0);
    for (int r = 1; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge Clk);
        FrameIn = 1'b1; LineIn = 1'b1; PixelIn = 8'd230;
      end
      @(negedge Clk);
      LineIn = 1'b0; PixelIn = 8'd0;
    end
    idle(4);

    // Frame B: 2x4 of zeros with 90 at (0,3).
    begin
      vec_t vb;
      vb = '{2, 4, 0, 0, 3, 90, 0, 3, 90, 0, 3, 0, 3, 90, 0, 0};
      drive_frame(vb);
    end
    idle(10);

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
